// File: rtl/attenuator.sv
// Button-stepped volume-cut stage: a debounced active-low push button cycles
// the target attenuation 0->1->2->3->0, and the applied shift ramps one step
// per RAMP_SAMPLES valid samples toward that target to avoid zipper noise.
// Optional build macro: ATTENUATOR_MUTE_EN (applied level 3 hard-mutes output).
//
// Button FSM states:
//   state   | meaning
//   IDLE    | button released; next debounced press advances the target
//   PRESSED | press accepted; waiting for debounced release
module attenuator #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RAMP_SAMPLES    = 64
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Button,
   input  logic        Sample_valid,
   input  logic [15:0] Data_in,
   output logic [15:0] Data_out,
   output logic        Out_valid,
   output logic [1:0]  atten_level
);

   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_SAMPLES - 1);

   typedef enum logic {IDLE = 1'b0, PRESSED = 1'b1} state_t;

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   state_t        state_q, state_d;
   logic          level_inc;
   logic [1:0]    level_q, level_d;
   logic [1:0]    applied_q, applied_d;
   logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [15:0]   dout_q, dout_d;
   logic          oval_q, oval_d;
   logic [15:0]   shifted;

   // Two-flop synchronizer; released (1) out of reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= Button;
         sync2_q <= sync1_q;
      end
   end

   // Debouncer: a new sync value must persist DEBOUNCE_CYCLES clocks.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      if (sync2_q == deb_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_d     = sync2_q;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + 1'b1;
      end
   end

   // Button FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Button FSM next state: one step per debounced press, however long held.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!deb_q) state_d = PRESSED;
         PRESSED: if (deb_q)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Button FSM output: pulse the target increment on entry to PRESSED.
   always_comb begin
      level_inc = 1'b0;
      if (state_q == IDLE && !deb_q) level_inc = 1'b1;
   end

   // Target level wraps naturally in two bits (3 -> 0).
   always_comb begin
      level_d = level_q + {1'b0, level_inc};
   end

   // Ramp: applied level moves one step toward target every RAMP_SAMPLES samples.
   always_comb begin
      applied_d  = applied_q;
      ramp_cnt_d = ramp_cnt_q;
      if (Sample_valid) begin
         if (applied_q == level_q) begin
            ramp_cnt_d = '0;
         end else if (ramp_cnt_q != RAMP_LAST) begin
            ramp_cnt_d = ramp_cnt_q + 1'b1;
         end else begin
            ramp_cnt_d = '0;
            if (level_q > applied_q) applied_d = applied_q + 2'd1;
            else                     applied_d = applied_q - 2'd1;
         end
      end
   end

   // Datapath: arithmetic shift by the level applied before this edge's update.
   always_comb begin
`ifdef ATTENUATOR_MUTE_EN
      if (applied_q == 2'd3) shifted = 16'h0000;
      else                   shifted = $signed(Data_in) >>> applied_q;
`else
      shifted = $signed(Data_in) >>> applied_q;
`endif
      dout_d = dout_q;
      oval_d = 1'b0;
      if (Sample_valid) begin
         dout_d = shifted;
         oval_d = 1'b1;
      end
   end

   // Control and datapath registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         deb_q      <= 1'b1;
         deb_cnt_q  <= '0;
         level_q    <= 2'd0;
         applied_q  <= 2'd0;
         ramp_cnt_q <= '0;
         dout_q     <= 16'h0000;
         oval_q     <= 1'b0;
      end else begin
         deb_q      <= deb_d;
         deb_cnt_q  <= deb_cnt_d;
         level_q    <= level_d;
         applied_q  <= applied_d;
         ramp_cnt_q <= ramp_cnt_d;
         dout_q     <= dout_d;
         oval_q     <= oval_d;
      end
   end

   assign Data_out    = dout_q;
   assign Out_valid   = oval_q;
   assign atten_level = level_q;

endmodule

// File: tb/tb_attenuator.sv
// Self-checking bench for attenuator (DEBOUNCE_CYCLES=16, RAMP_SAMPLES=4).
module tb_attenuator;

   localparam int DEB = 16;
   localparam int RS  = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Button;
   logic        Sample_valid;
   logic [15:0] Data_in;
   logic [15:0] Data_out;
   logic        Out_valid;
   logic [1:0]  atten_level;

   int checks   = 0;
   int failures = 0;

   // Reference model state: user target, applied level, samples since last step.
   int m_tgt, m_app, m_cnt;

   attenuator #(.DEBOUNCE_CYCLES(DEB), .RAMP_SAMPLES(RS)) dut (
      .Clk(Clk), .Reset(Reset), .Button(Button), .Sample_valid(Sample_valid),
      .Data_in(Data_in), .Data_out(Data_out), .Out_valid(Out_valid),
      .atten_level(atten_level)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected attenuated value: floor division by 2^level (or mute at 3).
   function automatic logic [15:0] ref_out(input logic [15:0] din, input int lvl);
      int x, d, q;
`ifdef ATTENUATOR_MUTE_EN
      if (lvl == 3) return 16'h0000;
`endif
      x = int'($signed(din));
      d = 1 << lvl;
      q = x / d;
      if ((x % d) != 0 && x < 0) q = q - 1;
      return 16'(q);
   endfunction

   task automatic model_reset();
      m_tgt = 0; m_app = 0; m_cnt = 0;
   endtask

   // Called at a negedge; returns at the next negedge with the sample checked.
   task automatic send_sample(input logic [15:0] din);
      logic [15:0] exp;
      exp = ref_out(din, m_app);
      Sample_valid = 1'b1;
      Data_in      = din;
      @(negedge Clk);
      Sample_valid = 1'b0;
      check("sample_out", 32'(Data_out), 32'(exp));
      check("sample_valid", 32'(Out_valid), 32'd1);
      if (m_app == m_tgt) m_cnt = 0;
      else if (m_cnt < RS - 1) m_cnt++;
      else begin
         m_cnt = 0;
         m_app = (m_tgt > m_app) ? m_app + 1 : m_app - 1;
      end
   endtask

   // Full press (held 40 clocks) and release; no samples during it.
   task automatic press();
      int k;
      int exp_lvl;
      exp_lvl = (m_tgt + 1) % 4;
      Button = 1'b0;
      k = 0;
      while (k < 60 && atten_level !== 2'(exp_lvl)) begin
         @(negedge Clk);
         k++;
      end
      check("press_level", 32'(atten_level), 32'(exp_lvl));
      check("press_latency_ok", 32'(k >= 16 && k <= 22), 32'd1);
      while (k < 40) begin
         @(negedge Clk);
         k++;
      end
      check("held_level", 32'(atten_level), 32'(exp_lvl));
      Button = 1'b1;
      repeat (25) @(negedge Clk);
      check("release_level", 32'(atten_level), 32'(exp_lvl));
      m_tgt = exp_lvl;
   endtask

   task automatic settle();
      int n;
      n = 0;
      while ((m_app != m_tgt) && n < 20) begin
         send_sample(16'($urandom));
         n++;
      end
   endtask

   logic [15:0] wrap_exp [4];

   initial begin
      Reset = 1'b1; Button = 1'b0; Sample_valid = 1'b1; Data_in = 16'h5a5a;
      model_reset();
      repeat (3) begin
         @(negedge Clk);
         check("rst_dout", 32'(Data_out), 32'h0);
         check("rst_oval", 32'(Out_valid), 32'h0);
         check("rst_level", 32'(atten_level), 32'h0);
      end
      Button = 1'b1; Sample_valid = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);

      // Passthrough at level 0, single-cycle valid
      send_sample(16'h1234);
      check("pass_1234", 32'(Data_out), 32'h1234);
      @(negedge Clk);
      check("oval_one_clk", 32'(Out_valid), 32'h0);
      check("dout_hold", 32'(Data_out), 32'h1234);

      // Single press, then ramp 0->1 after four samples
      press();
      for (int i = 0; i < 6; i++) begin
         send_sample(16'h8000);
         check("ramp01", 32'(Data_out), (i < 4) ? 32'h8000 : 32'hC000);
      end

      // Bounce rejection: 10-clock pulses never register
      for (int p = 0; p < 3; p++) begin
         Button = 1'b0;
         repeat (10) @(negedge Clk);
         Button = 1'b1;
         repeat (20) @(negedge Clk);
      end
      check("bounce_level", 32'(atten_level), 32'd1);

      // Reach level 3 (FSM must still be IDLE for this press to count)
      press();
      press();
      settle();
      send_sample(16'hFFFF);
`ifdef ATTENUATOR_MUTE_EN
      check("l3_ffff", 32'(Data_out), 32'h0000);
      send_sample(16'h0007);
      check("l3_0007", 32'(Data_out), 32'h0000);
      send_sample(16'h7FFF);
      check("l3_7fff", 32'(Data_out), 32'h0000);
      wrap_exp[0] = 16'h0000;
`else
      check("l3_ffff", 32'(Data_out), 32'hFFFF);
      send_sample(16'h0007);
      check("l3_0007", 32'(Data_out), 32'h0000);
      send_sample(16'h7FFF);
      check("l3_7fff", 32'(Data_out), 32'h0FFF);
      wrap_exp[0] = 16'h0800;
`endif
      wrap_exp[1] = 16'h1000; wrap_exp[2] = 16'h2000; wrap_exp[3] = 16'h4000;

      // Wrap press: target 0, applied ramps down 3->2->1->0
      press();
      check("wrap_level", 32'(atten_level), 32'd0);
      for (int i = 0; i < 16; i++) begin
         send_sample(16'h4000);
         check("wrap_ramp", 32'(Data_out), 32'(wrap_exp[i / 4]));
      end

      // Randomized samples with occasional presses and idle gaps
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) press();
         else begin
            send_sample(16'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
         end
      end

      // Reset mid-ramp with applied=2, target=0
      while (m_tgt != 2) press();
      settle();
      press();
      press();
      send_sample(16'h4000);
      check("midramp_applied2", 32'(Data_out), 32'h1000);
      Reset = 1'b1;
      @(negedge Clk);
      check("midrst_dout", 32'(Data_out), 32'h0);
      check("midrst_level", 32'(atten_level), 32'h0);
      Reset = 1'b0;
      model_reset();
      @(negedge Clk);
      send_sample(16'h4000);
      check("postrst_pass", 32'(Data_out), 32'h4000);
      check("postrst_level", 32'(atten_level), 32'h0);
      press();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
